// File: rtl/watch_pkg.sv
// Shared constants and record types for the watch/alarm timekeeping blocks.
// The optional 12-hour display is enabled by defining WATCH_HOUR12_EN.
package watch_pkg;

  localparam int SEC_MAX  = 60;
  localparam int MIN_MAX  = 60;
  localparam int HOUR_MAX = 24;

  localparam int SEC_BIT  = 6;
  localparam int MIN_BIT  = 6;
  localparam int HOUR_BIT = 5;
  localparam int DAY_BIT  = 9;

  typedef struct packed {
    logic [SEC_BIT-1:0]  sec;
    logic [MIN_BIT-1:0]  min;
    logic [HOUR_BIT-1:0] hour;
    logic [DAY_BIT-1:0]  day;
  } watch_time_t;

  typedef struct packed {
    logic                en;
    logic [MIN_BIT-1:0]  min;
    logic [HOUR_BIT-1:0] hour;
  } alarm_cfg_t;

endpackage

// File: rtl/watch_tick_gen.sv
// Programmable divider: o_tick is a combinational strobe marking the cycle whose
// rising edge ends a second. The caller registers it alongside the time update.
module watch_tick_gen #(
  parameter int P_COUNT_BIT = 30
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_run_en,
  input  logic [P_COUNT_BIT-1:0] i_freq,
  input  logic                   i_clear,
  output logic                   o_tick
);

  localparam logic [P_COUNT_BIT-1:0] L_ONE = P_COUNT_BIT'(1);

  logic [P_COUNT_BIT-1:0] r_cnt;
  logic                   w_terminal;

  // >= rather than == so that lowering i_freq below the current count ticks at once
  assign w_terminal = (i_freq <= L_ONE) || (r_cnt >= (i_freq - L_ONE));
  assign o_tick     = i_run_en && w_terminal && !i_clear;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_run_en) begin
      r_cnt <= w_terminal ? '0 : (r_cnt + L_ONE);
    end
  end

endmodule

// File: rtl/watch_alarm_top.sv
// Real-time clock with configurable day wrap, validated time load and a sticky
// hour:minute alarm. Define WATCH_HOUR12_EN for the 12-hour display ports.
module watch_alarm_top
  import watch_pkg::*;
#(
  parameter int P_COUNT_BIT = 30,
  parameter int P_SEC_BIT   = 6,
  parameter int P_MIN_BIT   = 6,
  parameter int P_HOUR_BIT  = 5,
  parameter int P_DAY_BIT   = 9,
  parameter int P_DAY_MAX   = 365
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_run_en,
  input  logic [P_COUNT_BIT-1:0] i_freq,
  input  logic                   i_set_valid,
  input  logic [P_SEC_BIT-1:0]   i_set_sec,
  input  logic [P_MIN_BIT-1:0]   i_set_min,
  input  logic [P_HOUR_BIT-1:0]  i_set_hour,
  input  logic [P_DAY_BIT-1:0]   i_set_day,
  input  logic                   i_alarm_wr,
  input  logic                   i_alarm_en,
  input  logic [P_MIN_BIT-1:0]   i_alarm_min,
  input  logic [P_HOUR_BIT-1:0]  i_alarm_hour,
  input  logic                   i_alarm_clr,
  output logic [P_SEC_BIT-1:0]   o_sec,
  output logic [P_MIN_BIT-1:0]   o_min,
  output logic [P_HOUR_BIT-1:0]  o_hour,
  output logic [P_DAY_BIT-1:0]   o_day,
  output logic                   o_tick,
  output logic                   o_day_wrap,
  output logic                   o_set_err,
`ifdef WATCH_HOUR12_EN
  input  logic                   i_mode12,
  output logic                   o_pm,
`endif
  output logic                   o_alarm
);

  localparam logic [P_SEC_BIT-1:0]  L_SEC_LAST  = P_SEC_BIT'(SEC_MAX - 1);
  localparam logic [P_MIN_BIT-1:0]  L_MIN_LAST  = P_MIN_BIT'(MIN_MAX - 1);
  localparam logic [P_HOUR_BIT-1:0] L_HOUR_LAST = P_HOUR_BIT'(HOUR_MAX - 1);
  localparam logic [P_DAY_BIT-1:0]  L_DAY_LAST  = P_DAY_BIT'(P_DAY_MAX - 1);
  localparam logic [P_SEC_BIT-1:0]  L_SEC_ONE   = P_SEC_BIT'(1);
  localparam logic [P_MIN_BIT-1:0]  L_MIN_ONE   = P_MIN_BIT'(1);
  localparam logic [P_HOUR_BIT-1:0] L_HOUR_ONE  = P_HOUR_BIT'(1);
  localparam logic [P_DAY_BIT-1:0]  L_DAY_ONE   = P_DAY_BIT'(1);

  logic [P_SEC_BIT-1:0]  r_sec;
  logic [P_MIN_BIT-1:0]  r_min;
  logic [P_HOUR_BIT-1:0] r_hour;
  logic [P_DAY_BIT-1:0]  r_day;
  logic                  r_tick;
  logic                  r_day_wrap;
  logic                  r_set_err;
  logic                  r_alarm;
  logic                  r_alarm_en;
  logic [P_MIN_BIT-1:0]  r_alarm_min;
  logic [P_HOUR_BIT-1:0] r_alarm_hour;

  logic                  w_set_ok;
  logic                  w_load;
  logic                  w_tick;
  logic                  w_sec_wrap;
  logic                  w_min_wrap;
  logic                  w_hour_wrap;
  logic                  w_day_wrap;
  logic [P_SEC_BIT-1:0]  w_next_sec;
  logic [P_MIN_BIT-1:0]  w_next_min;
  logic [P_HOUR_BIT-1:0] w_next_hour;
  logic [P_DAY_BIT-1:0]  w_next_day;
  logic                  w_alarm_hit;

  assign w_set_ok = (i_set_sec <= L_SEC_LAST) && (i_set_min <= L_MIN_LAST) &&
                    (i_set_hour <= L_HOUR_LAST) && (i_set_day <= L_DAY_LAST);
  assign w_load   = i_set_valid && w_set_ok;

  // An accepted load clears the divider, which also suppresses a coincident tick
  watch_tick_gen #(
    .P_COUNT_BIT (P_COUNT_BIT)
  ) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .i_run_en (i_run_en),
    .i_freq   (i_freq),
    .i_clear  (w_load),
    .o_tick   (w_tick)
  );

  assign w_sec_wrap  = (r_sec == L_SEC_LAST);
  assign w_min_wrap  = w_sec_wrap && (r_min == L_MIN_LAST);
  assign w_hour_wrap = w_min_wrap && (r_hour == L_HOUR_LAST);
  assign w_day_wrap  = w_hour_wrap && (r_day == L_DAY_LAST);

  assign w_next_sec  = w_sec_wrap ? '0 : (r_sec + L_SEC_ONE);
  assign w_next_min  = !w_sec_wrap ? r_min :
                       ((r_min == L_MIN_LAST) ? '0 : (r_min + L_MIN_ONE));
  assign w_next_hour = !w_min_wrap ? r_hour :
                       ((r_hour == L_HOUR_LAST) ? '0 : (r_hour + L_HOUR_ONE));
  assign w_next_day  = !w_hour_wrap ? r_day :
                       ((r_day == L_DAY_LAST) ? '0 : (r_day + L_DAY_ONE));

  // Only a counted second can fire; loads never reach this path
  assign w_alarm_hit = w_tick && r_alarm_en && (w_next_sec == '0) &&
                       (w_next_min == r_alarm_min) && (w_next_hour == r_alarm_hour);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sec        <= '0;
      r_min        <= '0;
      r_hour       <= '0;
      r_day        <= '0;
      r_tick       <= 1'b0;
      r_day_wrap   <= 1'b0;
      r_set_err    <= 1'b0;
      r_alarm      <= 1'b0;
      r_alarm_en   <= 1'b0;
      r_alarm_min  <= '0;
      r_alarm_hour <= '0;
    end else begin
      r_tick     <= 1'b0;
      r_day_wrap <= 1'b0;
      r_set_err  <= i_set_valid && !w_set_ok;

      if (i_alarm_wr) begin
        r_alarm_en   <= i_alarm_en;
        r_alarm_min  <= i_alarm_min;
        r_alarm_hour <= i_alarm_hour;
      end

      if (w_load) begin
        r_sec  <= i_set_sec;
        r_min  <= i_set_min;
        r_hour <= i_set_hour;
        r_day  <= i_set_day;
      end else if (w_tick) begin
        r_tick     <= 1'b1;
        r_day_wrap <= w_day_wrap;
        r_sec      <= w_next_sec;
        r_min      <= w_next_min;
        r_hour     <= w_next_hour;
        r_day      <= w_next_day;
      end

      if (w_alarm_hit) begin
        r_alarm <= 1'b1;
      end else if (i_alarm_clr) begin
        r_alarm <= 1'b0;
      end
    end
  end

  assign o_sec      = r_sec;
  assign o_min      = r_min;
  assign o_day      = r_day;
  assign o_tick     = r_tick;
  assign o_day_wrap = r_day_wrap;
  assign o_set_err  = r_set_err;
  assign o_alarm    = r_alarm;

`ifdef WATCH_HOUR12_EN
  localparam logic [P_HOUR_BIT-1:0] L_TWELVE = P_HOUR_BIT'(12);
  logic [P_HOUR_BIT-1:0] w_hour12;

  // Midnight and noon both read as 12 on a 12-hour face
  assign w_hour12 = (r_hour == '0)      ? L_TWELVE :
                    (r_hour > L_TWELVE) ? (r_hour - L_TWELVE) : r_hour;
  assign o_hour   = i_mode12 ? w_hour12 : r_hour;
  assign o_pm     = i_mode12 && (r_hour >= L_TWELVE);
`else
  assign o_hour   = r_hour;
`endif

endmodule

// File: tb/tb_watch_alarm_top.sv
// Directed bench for watch_alarm_top: load-validation table plus hand-written
// sequences for tick timing, day wrap, alarm, freeze, divider change and reset.
module tb_watch_alarm_top;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_run_en;
  logic [29:0] i_freq;
  logic        i_set_valid;
  logic [5:0]  i_set_sec;
  logic [5:0]  i_set_min;
  logic [4:0]  i_set_hour;
  logic [8:0]  i_set_day;
  logic        i_alarm_wr;
  logic        i_alarm_en;
  logic [5:0]  i_alarm_min;
  logic [4:0]  i_alarm_hour;
  logic        i_alarm_clr;
  logic [5:0]  o_sec;
  logic [5:0]  o_min;
  logic [4:0]  o_hour;
  logic [8:0]  o_day;
  logic        o_tick;
  logic        o_day_wrap;
  logic        o_set_err;
  logic        o_alarm;

  int total = 0;
  int bad   = 0;

  watch_alarm_top dut (
    .clk          (clk),
    .reset        (reset),
    .i_run_en     (i_run_en),
    .i_freq       (i_freq),
    .i_set_valid  (i_set_valid),
    .i_set_sec    (i_set_sec),
    .i_set_min    (i_set_min),
    .i_set_hour   (i_set_hour),
    .i_set_day    (i_set_day),
    .i_alarm_wr   (i_alarm_wr),
    .i_alarm_en   (i_alarm_en),
    .i_alarm_min  (i_alarm_min),
    .i_alarm_hour (i_alarm_hour),
    .i_alarm_clr  (i_alarm_clr),
    .o_sec        (o_sec),
    .o_min        (o_min),
    .o_hour       (o_hour),
    .o_day        (o_day),
    .o_tick       (o_tick),
    .o_day_wrap   (o_day_wrap),
    .o_set_err    (o_set_err),
    .o_alarm      (o_alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic vld;
    int   s, m, h, d;
    int   es, em, eh, ed;
    int   eerr;
  } vec_t;

  vec_t vecs[8];

  // One rising edge, then settle so outputs are sampled away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_time(input string name, input int s, input int m, input int h, input int d);
    chk({name, ".sec"},  int'(o_sec),  s);
    chk({name, ".min"},  int'(o_min),  m);
    chk({name, ".hour"}, int'(o_hour), h);
    chk({name, ".day"},  int'(o_day),  d);
  endtask

  task automatic drive_set(input int s, input int m, input int h, input int d);
    i_set_sec  = 6'(s);
    i_set_min  = 6'(m);
    i_set_hour = 5'(h);
    i_set_day  = 9'(d);
  endtask

  task automatic do_load(input int s, input int m, input int h, input int d);
    drive_set(s, m, h, d);
    i_set_valid = 1'b1;
    step();
    i_set_valid = 1'b0;
  endtask

  task automatic write_alarm(input logic en, input int m, input int h);
    i_alarm_en   = en;
    i_alarm_min  = 6'(m);
    i_alarm_hour = 5'(h);
    i_alarm_wr   = 1'b1;
    step();
    i_alarm_wr   = 1'b0;
  endtask

  // Steps until o_tick is seen; returns the number of edges taken
  task automatic wait_tick(input string name, output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      n++;
      if (o_tick) break;
    end
    if (!o_tick) begin
      total++;
      bad++;
      $display("FAIL %s: no tick within %0d cycles (got 0 expected 1)", name, n);
    end
  endtask

  initial begin
    int n;
    int ticks;
    int gap;
    int bad_gap;
    int seen;

    reset        = 1'b0;
    i_run_en     = 1'b0;
    i_freq       = 30'd10;
    i_set_valid  = 1'b0;
    i_alarm_wr   = 1'b0;
    i_alarm_en   = 1'b0;
    i_alarm_clr  = 1'b0;
    i_alarm_min  = '0;
    i_alarm_hour = '0;
    drive_set(0, 0, 0, 0);

    vecs[0] = '{1'b1, 10, 20, 3, 100, 10, 20, 3, 100, 0};
    vecs[1] = '{1'b1, 60,  0, 0,   0, 10, 20, 3, 100, 1};
    vecs[2] = '{1'b1,  0, 60, 0,   0, 10, 20, 3, 100, 1};
    vecs[3] = '{1'b0,  1,  1, 1,   1, 10, 20, 3, 100, 0};
    vecs[4] = '{1'b1,  0,  0, 24,  0, 10, 20, 3, 100, 1};
    vecs[5] = '{1'b1,  0,  0, 0, 365, 10, 20, 3, 100, 1};
    vecs[6] = '{1'b1, 59, 59, 23, 364, 59, 59, 23, 364, 0};
    vecs[7] = '{1'b1,  0,  0, 0,   0,  0,  0, 0,   0, 0};

    step();
    step();
    chk_time("reset", 0, 0, 0, 0);
    chk("reset.tick", int'(o_tick), 0);
    chk("reset.alarm", int'(o_alarm), 0);
    chk("reset.set_err", int'(o_set_err), 0);
    reset = 1'b1;

    // Load validation with the divider stopped
    for (int v = 0; v < 8; v++) begin
      drive_set(vecs[v].s, vecs[v].m, vecs[v].h, vecs[v].d);
      i_set_valid = vecs[v].vld;
      step();
      chk_time($sformatf("vec%0d", v), vecs[v].es, vecs[v].em, vecs[v].eh, vecs[v].ed);
      chk($sformatf("vec%0d.set_err", v), int'(o_set_err), vecs[v].eerr);
      chk($sformatf("vec%0d.tick", v), int'(o_tick), 0);
    end
    i_set_valid = 1'b0;

    // 600 ticks at 10 cycles each -> 00:10:00
    i_run_en = 1'b1;
    ticks = 0;
    gap = 0;
    bad_gap = 0;
    for (int c = 0; c < 7000; c++) begin
      step();
      gap++;
      if (o_tick) begin
        ticks++;
        if (gap != 10) bad_gap++;
        gap = 0;
        if (ticks == 600) break;
      end
    end
    chk("run.tick_count", ticks, 600);
    chk("run.bad_periods", bad_gap, 0);
    chk_time("run", 0, 10, 0, 0);

    // Day wrap from 23:59:59 on the last day
    do_load(59, 59, 23, 364);
    wait_tick("wrap.wait", n);
    chk("wrap.latency", n, 10);
    chk_time("wrap", 0, 0, 0, 0);
    chk("wrap.day_wrap", int'(o_day_wrap), 1);
    step();
    chk("wrap.day_wrap_clear", int'(o_day_wrap), 0);
    chk("wrap.tick_clear", int'(o_tick), 0);

    // Load on the same edge as a tick: load wins, divider restarts
    wait_tick("collide.sync", n);
    for (int i = 0; i < 9; i++) step();
    do_load(1, 2, 3, 4);
    chk("collide.tick", int'(o_tick), 0);
    chk("collide.set_err", int'(o_set_err), 0);
    chk_time("collide", 1, 2, 3, 4);
    wait_tick("collide.next", n);
    chk("collide.latency", n, 10);
    chk_time("collide.after", 2, 2, 3, 4);

    // Alarm at 07:30
    write_alarm(1'b1, 30, 7);
    chk("alarm.initial", int'(o_alarm), 0);
    do_load(58, 29, 7, 0);
    wait_tick("alarm.t1", n);
    chk_time("alarm.t1", 59, 29, 7, 0);
    chk("alarm.t1.flag", int'(o_alarm), 0);
    wait_tick("alarm.t2", n);
    chk_time("alarm.t2", 0, 30, 7, 0);
    chk("alarm.fire", int'(o_alarm), 1);
    for (int i = 0; i < 3; i++) step();
    chk("alarm.sticky", int'(o_alarm), 1);
    do_load(59, 29, 7, 0);
    for (int i = 0; i < 9; i++) step();
    i_alarm_clr = 1'b1;
    step();
    chk("alarm.fire_clr.tick", int'(o_tick), 1);
    chk("alarm.fire_clr.min", int'(o_min), 30);
    chk("alarm.fire_clr", int'(o_alarm), 1);
    step();
    i_alarm_clr = 1'b0;
    chk("alarm.clr", int'(o_alarm), 0);
    do_load(0, 30, 7, 0);
    step();
    chk("alarm.load_no_fire", int'(o_alarm), 0);

    // Freeze with run_en low, then lower the divider mid-count
    do_load(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step();
    i_run_en = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (o_tick) seen++;
    end
    chk("freeze.ticks", seen, 0);
    chk_time("freeze", 0, 0, 0, 1);
    i_run_en = 1'b1;
    wait_tick("freeze.resume", n);
    chk("freeze.resume_latency", n, 5);
    chk("freeze.resume_sec", int'(o_sec), 1);
    for (int i = 0; i < 7; i++) step();
    chk("freq.before_change", int'(o_tick), 0);
    i_freq = 30'd3;
    step();
    chk("freq.drop_tick", int'(o_tick), 1);
    i_freq = 30'd0;
    step();
    chk("freq.zero_tick", int'(o_tick), 1);
    i_freq = 30'd1;
    step();
    chk("freq.one_tick", int'(o_tick), 1);
    chk("freq.sec", int'(o_sec), 4);
    i_freq = 30'd10;

    // Reset mid-operation, with a valid load presented in the same cycle
    write_alarm(1'b1, 35, 12);
    do_load(56, 34, 12, 0);
    for (int i = 0; i < 4; i++) step();
    reset = 1'b0;
    drive_set(10, 10, 10, 10);
    i_set_valid = 1'b1;
    step();
    i_set_valid = 1'b0;
    chk_time("midreset", 0, 0, 0, 0);
    chk("midreset.tick", int'(o_tick), 0);
    chk("midreset.alarm", int'(o_alarm), 0);
    chk("midreset.set_err", int'(o_set_err), 0);
    reset = 1'b1;
    do_load(59, 34, 12, 0);
    wait_tick("midreset.disarm", n);
    chk_time("midreset.after", 0, 35, 12, 0);
    chk("midreset.disarmed", int'(o_alarm), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/watch_alarm_top.md
Name: watch_alarm_top

Overview:
Parametrised successor to watch_top. Same runtime-programmable 1 Hz tick derived from i_freq, and the same sec/min/hour/day cascade. Adds:
- a configurable day-wrap limit
- a validated time-load (set) port
- an hour:minute alarm with a sticky flag
Sits at the top of the timekeeping subsystem.

Parameters:
P_COUNT_BIT, 30, tick-divider width (i_freq < 2^30, under 1 GHz)
P_SEC_BIT, 6, seconds width
P_MIN_BIT, 6, minutes width
P_HOUR_BIT, 5, hours width
P_DAY_BIT, 9, day-counter width
P_DAY_MAX, 365, number of days before wrap (must be ≤ 2^P_DAY_BIT)

Ports:
clk  in  1  single system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
i_run_en  in  1  tick counter advances only when 1
i_freq  in  P_COUNT_BIT  clk cycles per second
i_set_valid  in  1  one-cycle load strobe
i_set_sec/i_set_min/i_set_hour/i_set_day  in  P_*_BIT  load values
i_alarm_wr  in  1  latch alarm configuration
i_alarm_en  in  1  alarm arm bit, captured on i_alarm_wr
i_alarm_min/i_alarm_hour  in  P_MIN_BIT/P_HOUR_BIT  alarm time
i_alarm_clr  in  1  clears o_alarm
o_sec/o_min/o_hour/o_day  out  P_*_BIT  current time
o_tick  out  1  one-cycle pulse per second
o_day_wrap  out  1  one-cycle pulse when day wraps P_DAY_MAX-1 -> 0
o_set_err  out  1  one-cycle pulse when a load is rejected
o_alarm  out  1  sticky alarm flag

Behaviour:
- Reset (reset==0 at clk edge): all counters, time and outputs go to 0; alarm configuration goes to 0 (disarmed).
- Tick counter:
  - Counts while i_run_en=1; holds while i_run_en=0.
  - Tick fires when cnt >= i_freq-1; cnt then returns to 0.
  - The >= compare covers an i_freq reduced mid-count.
  - i_freq of 0 or 1 means a tick on every enabled cycle.
- o_tick is registered: asserted in cycle N+1 after the terminal count at edge N. Time outputs update in the same cycle as o_tick.
- Cascade on tick:
  - sec 0..59, min 0..59, hour 0..23, day 0..P_DAY_MAX-1.
  - Each carry ripples within the same cycle, so 23:59:59 on day D becomes 00:00:00 on day D+1.
  - On day wrap, day becomes 0 and o_day_wrap pulses together with o_tick.
- Load:
  - Accepted when sec<60, min<60, hour<24 and day<P_DAY_MAX.
  - Accepted load: fields are written and the tick counter clears to 0, so the next tick comes a full i_freq cycles later.
  - Rejected load: time is unchanged and o_set_err pulses in the next cycle.
  - Load works regardless of i_run_en.
  - Load beats a tick in the same cycle; that tick is discarded.
- Alarm:
  - i_alarm_wr captures the en, min and hour fields.
  - Fires only on a tick whose new time is hour==alarm_hour, min==alarm_min, sec==0, with alarm_en=1.
  - A load never fires the alarm.
  - o_alarm sets and holds until i_alarm_clr.
  - Fire and clear in the same cycle: fire wins and o_alarm stays 1.
  - Writing an alarm with en=0 does not clear o_alarm.
- Reset asserted mid-operation overrides all other inputs in that cycle.

Optional Feature:
WATCH_HOUR12_EN:
- Defined: adds an i_mode12 input and an o_pm output. When i_mode12=1, o_hour shows 12,1..11 and o_pm = (internal hour >= 12).
- Alarm compare and load always use internal 24-hour values.
- Undefined: neither port exists and o_hour is 0..23.

Decomposition:
- Package watch_pkg holds:
  - localparams SEC_MAX=60, MIN_MAX=60, HOUR_MAX=24
  - a typedef struct for time {sec, min, hour, day}, widths from package-default bit params
  - a typedef struct for alarm configuration
- Sub-module watch_tick_gen: i_run_en, i_freq and a clear input -> o_tick. The top instantiates it and adds the cascade, load and alarm logic.

Test Plan:
1. i_freq=10, i_run_en=1 after reset release -> o_tick every 10 cycles; after 600 ticks, o_min=10 and o_sec=0.
2. Load 23:59:59 with day=P_DAY_MAX-1=364, then one tick -> 00:00:00, day 0, o_day_wrap=1 for exactly 1 cycle.
3. Load sec=60 -> o_set_err pulses 1 cycle and time is unchanged. Load in the same cycle as a tick -> loaded value is held and the tick counter restarts.
4. Alarm 07:30 armed, load 07:29:58, two ticks -> o_alarm=1 and stays set. Clear together with a fire -> remains 1. Clear alone -> 0.
5. i_run_en=0 for 25 cycles mid-count -> no tick and time frozen. i_freq changed from 10 to 3 with cnt=7 -> tick on the next cycle.
6. Assert reset (0) mid-count at 12:34:56 -> all outputs 0 the next cycle; alarm disarmed.
